// File: rtl/shrg_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module : shrg_ctrl_if
// Brief  : Request/serial/parallel bundle between a requester, shrg_ctrl and
//          the external shift register it sequences.
// Rev    : 1.0
//==============================================================================
interface shrg_ctrl_if #(
    parameter int N = 10
);
    logic         start;
    logic         mode;
    logic [N-1:0] wdata;
    logic         rx;
    logic         abort;
    logic [N-1:0] o;
    logic [N-1:0] i;
    logic         wri;
    logic         shift;
    logic         set;
    logic         data;
    logic         busy;
    logic         done;
    logic [N-1:0] rdata;

    // Requester side; it also drives o, since it owns the shift register.
    modport master (
        output start, mode, wdata, rx, abort, o,
        input  i, wri, shift, set, data, busy, done, rdata
    );

    modport slave (
        input  start, mode, wdata, rx, abort, o,
        output i, wri, shift, set, data, busy, done, rdata
    );
endinterface
`default_nettype wire

// File: rtl/shrg_ctrl.sv
`default_nettype none
//==============================================================================
// Module : shrg_ctrl
// Brief  : Sequences an external N-bit shift register: load, N divided shift
//          steps, commit. All outputs are registered.
// Rev    : 1.0
//==============================================================================
module shrg_ctrl #(
    parameter int N   = 10,
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    shrg_ctrl_if.slave bus
);

    localparam int            BW         = $clog2(N + 1);
    localparam logic [BW-1:0] c_last_bit = BW'(N - 1);
    localparam logic [7:0]    c_div_last = 8'(DIV - 1);
    localparam logic          c_div_one  = (DIV == 1);

    generate
        if (DIV < 1 || DIV > 255) begin : g_div_range_check
            $error("shrg_ctrl: DIV must be within 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_mode;
    logic [7:0]    r_div_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [N-1:0]  r_i;
    logic          r_wri;
    logic          r_shift;
    logic          r_set;
    logic          r_data;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_rdata;

    // Strobes are decided one edge ahead, so each appears in the cycle that
    // the corresponding state / divider value is current.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_i       <= '0;
            r_wri     <= 1'b0;
            r_shift   <= 1'b0;
            r_set     <= 1'b0;
            r_data    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_i     <= '0;
            r_wri   <= 1'b0;
            r_shift <= 1'b0;
            r_set   <= 1'b0;
            r_data  <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        r_mode  <= bus.mode;
                        r_i     <= bus.mode ? '0 : bus.wdata;
                        r_wri   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (bus.abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_shift <= c_div_one;
                        r_data  <= r_mode & bus.rx;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (bus.abort) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_div_cnt == c_div_last) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                        if (r_bit_cnt == c_last_bit) begin
                            r_set   <= 1'b1;
                            r_state <= S_COMMIT;
                        end else begin
                            r_shift <= c_div_one;
                            r_data  <= r_mode & bus.rx;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                        r_shift   <= ((r_div_cnt + 8'd1) == c_div_last);
                        r_data    <= r_mode & bus.rx;
                    end
                end

                S_COMMIT: begin
                    r_div_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_busy    <= 1'b0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rdata <= bus.o;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.i     = r_i;
    assign bus.wri   = r_wri;
    assign bus.shift = r_shift;
    assign bus.set   = r_set;
    assign bus.data  = r_data;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire
